// File: rtl/hwpe_ctrl_useq_pkg.sv
// Shared types, default sizes and helpers for the HWPE microcode loop sequencer.
package hwpe_ctrl_useq_pkg;

  localparam int unsigned DEF_NB_LOOPS  = 6;
  localparam int unsigned DEF_LENGTH    = 16;
  localparam int unsigned DEF_NB_REG    = 4;
  localparam int unsigned DEF_NB_RO_REG = 28;
  localparam int unsigned DEF_REG_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH = 12;
  localparam int unsigned DEF_ADDR_W    = $clog2(DEF_LENGTH);
  localparam int unsigned DEF_OPND_W    =
    $clog2(DEF_NB_RO_REG > DEF_NB_REG ? DEF_NB_RO_REG : DEF_NB_REG);

  typedef enum logic [1:0] {IDLE, EMIT, UPDATE, DONE} useq_state_t;

  // One micro-op at default sizes: reg[a] += op_sel ? reg[b] : ro_regs[b]
  typedef struct packed {
    logic                  op_sel;
    logic [DEF_OPND_W-1:0] a;
    logic [DEF_OPND_W-1:0] b;
  } useq_op_t;

  // Index width that stays at least one bit for single-entry sizes
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_useq_loop_sel.sv
// Finds the lowest loop whose index has not yet reached range-1 (range 0 counts as 1).
module hwpe_ctrl_useq_loop_sel
  import hwpe_ctrl_useq_pkg::*;
#(
  parameter int unsigned NB_LOOPS  = DEF_NB_LOOPS,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned SEL_W     = clog2_min1(NB_LOOPS)
) (
  input  logic [NB_LOOPS*CNT_WIDTH-1:0] idx,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0] range_cnt,
  output logic [SEL_W-1:0]              sel_c,
  output logic                          all_done_c
);

  logic [NB_LOOPS-1:0] last;

  // >= keeps a counter from ever stepping past range-1
  always_comb begin
    last = '0;
    for (int unsigned j = 0; j < NB_LOOPS; j++) begin
      last[j] = (range_cnt[j*CNT_WIDTH +: CNT_WIDTH] == '0) ||
                (idx[j*CNT_WIDTH +: CNT_WIDTH] >=
                 range_cnt[j*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1));
    end
  end

  always_comb begin
    sel_c      = '0;
    all_done_c = 1'b1;
    for (int unsigned j = 0; j < NB_LOOPS; j++) begin
      if (all_done_c && !last[j]) begin
        sel_c      = SEL_W'(j);
        all_done_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hwpe_ctrl_useq.sv
// Microcode loop sequencer: walks nested loops, runs per-loop micro-ops, emits offs/idx tuples.
// Optional HWPE_CTRL_USEQ_SHADOW_EN latches the program inputs on start.
module hwpe_ctrl_useq
  import hwpe_ctrl_useq_pkg::*;
#(
  parameter int unsigned NB_LOOPS  = DEF_NB_LOOPS,
  parameter int unsigned LENGTH    = DEF_LENGTH,
  parameter int unsigned NB_REG    = DEF_NB_REG,
  parameter int unsigned NB_RO_REG = DEF_NB_RO_REG,
  parameter int unsigned REG_WIDTH = DEF_REG_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned ADDR_W    = clog2_min1(LENGTH),
  parameter int unsigned OPND_W    = clog2_min1(NB_REG > NB_RO_REG ? NB_REG : NB_RO_REG),
  parameter int unsigned ACC_W     = clog2_min1(NB_LOOPS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             start_i,
  input  logic                             ready_i,
  input  logic [NB_LOOPS*ADDR_W-1:0]       loop_addr_i,
  input  logic [NB_LOOPS*(ADDR_W+1)-1:0]   loop_nbops_i,
  input  logic [LENGTH*(1+2*OPND_W)-1:0]   code_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]    range_i,
  input  logic [NB_RO_REG*REG_WIDTH-1:0]   ro_regs_i,
  input  logic [ACC_W-1:0]                 accum_loop_i,
  output logic                             valid_o,
  output logic [NB_REG*REG_WIDTH-1:0]      offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]    idx_o,
  output logic                             accum_o,
  output logic                             done_o,
  output logic                             busy_o
);

  localparam int unsigned OP_W    = 1 + 2*OPND_W;
  localparam int unsigned NBOPS_W = ADDR_W + 1;

  useq_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]   idx_q  [NB_LOOPS];
  logic [CNT_WIDTH-1:0]   idx_d  [NB_LOOPS];
  logic [REG_WIDTH-1:0]   offs_q [NB_REG];
  logic [REG_WIDTH-1:0]   offs_d [NB_REG];
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [NBOPS_W-1:0]     cnt_q, cnt_d;
  logic                   valid_d, done_d, busy_d, accum_d;

  logic [NB_LOOPS*ADDR_W-1:0]     loop_addr_e;
  logic [NB_LOOPS*NBOPS_W-1:0]    loop_nbops_e;
  logic [LENGTH*OP_W-1:0]         code_e;
  logic [NB_LOOPS*CNT_WIDTH-1:0]  range_e;
  logic [ACC_W-1:0]               accum_loop_e;

`ifdef HWPE_CTRL_USEQ_SHADOW_EN
  logic [NB_LOOPS*ADDR_W-1:0]     loop_addr_s;
  logic [NB_LOOPS*NBOPS_W-1:0]    loop_nbops_s;
  logic [LENGTH*OP_W-1:0]         code_s;
  logic [NB_LOOPS*CNT_WIDTH-1:0]  range_s;
  logic [ACC_W-1:0]               accum_loop_s;

  // Program snapshot taken when a sequence is launched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loop_addr_s  <= '0;
      loop_nbops_s <= '0;
      code_s       <= '0;
      range_s      <= '0;
      accum_loop_s <= '0;
    end else if (state_q == IDLE && start_i && !clear_i) begin
      loop_addr_s  <= loop_addr_i;
      loop_nbops_s <= loop_nbops_i;
      code_s       <= code_i;
      range_s      <= range_i;
      accum_loop_s <= accum_loop_i;
    end
  end

  assign loop_addr_e  = loop_addr_s;
  assign loop_nbops_e = loop_nbops_s;
  assign code_e       = code_s;
  assign range_e      = range_s;
  assign accum_loop_e = accum_loop_s;
`else
  assign loop_addr_e  = loop_addr_i;
  assign loop_nbops_e = loop_nbops_i;
  assign code_e       = code_i;
  assign range_e      = range_i;
  assign accum_loop_e = accum_loop_i;
`endif

  logic [NB_LOOPS*CNT_WIDTH-1:0] idx_flat;
  logic [ACC_W-1:0]              sel;
  logic                          all_done;
  logic [ADDR_W-1:0]             sel_addr;
  logic [NBOPS_W-1:0]            sel_nbops;
  logic [OP_W-1:0]               op_word;
  logic                          op_sel;
  logic [OPND_W-1:0]             op_a, op_b;
  logic [REG_WIDTH-1:0]          opnd;

  always_comb begin
    idx_flat = '0;
    for (int unsigned j = 0; j < NB_LOOPS; j++) idx_flat[j*CNT_WIDTH +: CNT_WIDTH] = idx_q[j];
  end

  hwpe_ctrl_useq_loop_sel #(
    .NB_LOOPS  (NB_LOOPS),
    .CNT_WIDTH (CNT_WIDTH),
    .SEL_W     (ACC_W)
  ) i_loop_sel (
    .idx        (idx_flat),
    .range_cnt  (range_e),
    .sel_c      (sel),
    .all_done_c (all_done)
  );

  always_comb begin
    sel_addr  = '0;
    sel_nbops = '0;
    for (int unsigned j = 0; j < NB_LOOPS; j++) begin
      if (sel == ACC_W'(j)) begin
        sel_addr  = loop_addr_e[j*ADDR_W +: ADDR_W];
        sel_nbops = loop_nbops_e[j*NBOPS_W +: NBOPS_W];
      end
    end
  end

  // Micro-op fetch and operand read; out-of-range operand indices read 0
  always_comb begin
    op_word = '0;
    for (int unsigned i = 0; i < LENGTH; i++)
      if (ptr_q == ADDR_W'(i)) op_word = code_e[i*OP_W +: OP_W];
    op_sel = op_word[OP_W-1];
    op_a   = op_word[OP_W-2 -: OPND_W];
    op_b   = op_word[OPND_W-1:0];
    opnd   = '0;
    for (int unsigned i = 0; i < NB_REG; i++)
      if (op_sel && op_b == OPND_W'(i)) opnd = offs_q[i];
    for (int unsigned i = 0; i < NB_RO_REG; i++)
      if (!op_sel && op_b == OPND_W'(i)) opnd = ro_regs_i[i*REG_WIDTH +: REG_WIDTH];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    offs_d  = offs_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = EMIT;
          for (int unsigned j = 0; j < NB_LOOPS; j++) idx_d[j] = '0;
          for (int unsigned i = 0; i < NB_REG; i++) offs_d[i] = '0;
        end
      end
      EMIT: begin
        if (ready_i) begin
          if (all_done) begin
            state_d = DONE;
          end else begin
            for (int unsigned j = 0; j < NB_LOOPS; j++) begin
              if (ACC_W'(j) == sel)     idx_d[j] = idx_q[j] + CNT_WIDTH'(1);
              else if (ACC_W'(j) < sel) idx_d[j] = '0;
            end
            ptr_d   = sel_addr;
            cnt_d   = sel_nbops;
            state_d = (sel_nbops == '0) ? EMIT : UPDATE;
          end
        end
      end
      UPDATE: begin
        for (int unsigned i = 0; i < NB_REG; i++)
          if (op_a == OPND_W'(i)) offs_d[i] = offs_q[i] + opnd;
        ptr_d = (ptr_q == ADDR_W'(LENGTH-1)) ? '0 : ptr_q + ADDR_W'(1);
        cnt_d = cnt_q - NBOPS_W'(1);
        if (cnt_q <= NBOPS_W'(1)) state_d = EMIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_i) begin
      state_d = IDLE;
      for (int unsigned j = 0; j < NB_LOOPS; j++) idx_d[j] = '0;
      for (int unsigned i = 0; i < NB_REG; i++) offs_d[i] = '0;
      ptr_d = '0;
      cnt_d = '0;
    end

    valid_d = (state_d == EMIT);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    accum_d = valid_d;
    for (int unsigned j = 0; j < NB_LOOPS; j++)
      if (j < 32'(accum_loop_e) && idx_d[j] != '0) accum_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      for (int unsigned j = 0; j < NB_LOOPS; j++) idx_q[j] <= '0;
      for (int unsigned i = 0; i < NB_REG; i++) offs_q[i] <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
      accum_o <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      offs_q  <= offs_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_o <= valid_d;
      done_o  <= done_d;
      busy_o  <= busy_d;
      accum_o <= accum_d;
    end
  end

  for (genvar g = 0; g < NB_REG; g++) begin : g_offs
    assign offs_o[g*REG_WIDTH +: REG_WIDTH] = offs_q[g];
  end
  for (genvar g = 0; g < NB_LOOPS; g++) begin : g_idx
    assign idx_o[g*CNT_WIDTH +: CNT_WIDTH] = idx_q[g];
  end

endmodule

// File: tb/tb_hwpe_ctrl_useq.sv
// Directed, table-driven bench for the microcode loop sequencer.
module tb_hwpe_ctrl_useq;
  import hwpe_ctrl_useq_pkg::*;

  localparam int unsigned NL = 6, LEN = 16, NR = 4, NRO = 28, RW = 32, CW = 12;
  localparam int unsigned AW = 4, OW = 5, OPW = 11, ACW = 3;

  typedef struct packed {
    logic [31:0] offs0;
    logic [31:0] offs1;
    logic [11:0] idx0;
    logic [11:0] idx1;
    logic        accum;
  } tuple_t;

  logic                clk_i = 1'b0;
  logic                rst_ni, clear_i, start_i, ready_i;
  logic [NL*AW-1:0]    loop_addr_i;
  logic [NL*(AW+1)-1:0] loop_nbops_i;
  logic [LEN*OPW-1:0]  code_i;
  logic [NL*CW-1:0]    range_i;
  logic [NRO*RW-1:0]   ro_regs_i;
  logic [ACW-1:0]      accum_loop_i;
  logic                valid_o, accum_o, done_o, busy_o;
  logic [NR*RW-1:0]    offs_o;
  logic [NL*CW-1:0]    idx_o;

  int n_tests = 0, n_fail = 0;
  int done_cnt, done_cyc;
  tuple_t got_q[$];
  tuple_t exp_q[$];
  int hs_cyc[$];
  tuple_t tab2[6];
  tuple_t tab4[4];
  tuple_t tab5[6];

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_useq #(
    .NB_LOOPS(NL), .LENGTH(LEN), .NB_REG(NR), .NB_RO_REG(NRO), .REG_WIDTH(RW), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .ready_i(ready_i),
    .loop_addr_i(loop_addr_i), .loop_nbops_i(loop_nbops_i), .code_i(code_i), .range_i(range_i),
    .ro_regs_i(ro_regs_i), .accum_loop_i(accum_loop_i), .valid_o(valid_o), .offs_o(offs_o),
    .idx_o(idx_o), .accum_o(accum_o), .done_o(done_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 0);
    chk({tag, "_done"},  64'(done_o), 0);
    chk({tag, "_busy"},  64'(busy_o), 0);
    chk({tag, "_accum"}, 64'(accum_o), 0);
    chk({tag, "_offs_nz"}, 64'(offs_o != '0), 0);
    chk({tag, "_idx_nz"},  64'(idx_o != '0), 0);
  endtask

  task automatic cfg_clear();
    loop_addr_i = '0; loop_nbops_i = '0; code_i = '0; range_i = '0; accum_loop_i = '0;
    ro_regs_i = '0;
    ro_regs_i[0*RW +: RW] = 32'd4;
    ro_regs_i[1*RW +: RW] = 32'd100;
  endtask

  task automatic cfg_loop(input int l, input int addr, input int nbops, input int rng);
    loop_addr_i[l*AW +: AW]           = AW'(addr);
    loop_nbops_i[l*(AW+1) +: (AW+1)]  = (AW+1)'(nbops);
    range_i[l*CW +: CW]               = CW'(rng);
  endtask

  task automatic cfg_op(input int p, input bit sel, input int a, input int b);
    useq_op_t op;
    op.op_sel = sel; op.a = OW'(a); op.b = OW'(b);
    code_i[p*OPW +: OPW] = op;
  endtask

  // Two-loop program: loop0 reg0+=ro0; loop1 runs reg0+=ro0 then reg1+=ro1
  task automatic prog2();
    cfg_clear();
    cfg_op(0, 1'b0, 0, 0);
    cfg_op(1, 1'b0, 1, 1);
    cfg_loop(0, 0, 1, 3);
    cfg_loop(1, 0, 2, 2);
  endtask

  task automatic run_seq(input int rp);
    bit held, fin;
    int post;
    logic [NR*RW-1:0] s_offs;
    logic [NL*CW-1:0] s_idx;
    tuple_t t;
    got_q.delete(); hs_cyc.delete();
    done_cnt = 0; done_cyc = -1; held = 0; fin = 0; post = 0;
    s_offs = '0; s_idx = '0;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      ready_i = (rp <= 1) || ((c % rp) == rp - 1);
      if (done_o) begin done_cnt++; done_cyc = c; end
      if (held) begin
        n_tests++;
        if (!valid_o || offs_o !== s_offs || idx_o !== s_idx) begin
          n_fail++;
          $display("FAIL hold_c%0d: valid=%0b offs=%0h idx=%0h required offs=%0h idx=%0h",
                   c, valid_o, offs_o, idx_o, s_offs, s_idx);
        end
      end
      held = 0;
      if (valid_o) begin
        if (ready_i) begin
          t.offs0 = offs_o[31:0];  t.offs1 = offs_o[63:32];
          t.idx0  = idx_o[11:0];   t.idx1  = idx_o[23:12];
          t.accum = accum_o;
          got_q.push_back(t);
          hs_cyc.push_back(c);
        end else begin
          held = 1; s_offs = offs_o; s_idx = idx_o;
        end
      end
      if (done_cnt > 0 && !busy_o) begin
        post++;
        if (post == 3) fin = 1;
      end
      if (!fin) begin @(posedge clk_i); #1; end
    end
    ready_i = 1'b0;
    chk("run_terminated", 64'(fin), 1);
  endtask

  task automatic cmp_run(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_t%0d_offs0", tag, i), got_q[i].offs0, exp_q[i].offs0);
      chk($sformatf("%s_t%0d_offs1", tag, i), got_q[i].offs1, exp_q[i].offs1);
      chk($sformatf("%s_t%0d_idx0",  tag, i), got_q[i].idx0,  exp_q[i].idx0);
      chk($sformatf("%s_t%0d_idx1",  tag, i), got_q[i].idx1,  exp_q[i].idx1);
      chk($sformatf("%s_t%0d_accum", tag, i), got_q[i].accum, exp_q[i].accum);
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    bit found;
    int lat;
    // expected tuples: {offs0, offs1, idx0, idx1, accum}
    tab2[0] = '{32'd0,  32'd0,   12'd0, 12'd0, 1'b1};
    tab2[1] = '{32'd4,  32'd0,   12'd1, 12'd0, 1'b1};
    tab2[2] = '{32'd8,  32'd0,   12'd2, 12'd0, 1'b1};
    tab2[3] = '{32'd12, 32'd100, 12'd0, 12'd1, 1'b1};
    tab2[4] = '{32'd16, 32'd100, 12'd1, 12'd1, 1'b1};
    tab2[5] = '{32'd20, 32'd100, 12'd2, 12'd1, 1'b1};
    for (int i = 0; i < 4; i++) tab4[i] = '{32'd0, 32'd0, 12'(i), 12'd0, 1'b1};
    for (int i = 0; i < 6; i++) tab5[i] = '{32'd0, 32'd0, 12'(i % 2), 12'(i / 2), 1'(i % 2 == 0)};

    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    cfg_clear();
    repeat (3) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_zero("idle");

    // Reset asserted while micro-ops are running
    prog2();
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (busy_o && !valid_o && !done_o) found = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk("mid_update_seen", 64'(found), 1);
    chk("mid_update_idx0", 64'(idx_o[11:0]), 1);
    #2 rst_ni = 1'b0;
    #1 check_zero("rst_mid");
    ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_zero("rst_after");

    // Two nested loops, always ready
    prog2();
    run_seq(1);
    exp_q.delete(); for (int i = 0; i < 6; i++) exp_q.push_back(tab2[i]);
    cmp_run("seq2");
    lat = (hs_cyc.size() >= 6) ? hs_cyc[5] - hs_cyc[0] : -1;
    chk("seq2_span", lat, 11);
    lat = (hs_cyc.size() >= 6) ? done_cyc - hs_cyc[5] : -1;
    chk("seq2_done_lat", lat, 1);
    chk("seq2_hold_offs0", 64'(offs_o[31:0]), 20);
    chk("seq2_hold_idx0",  64'(idx_o[11:0]), 2);

    // Same program under back-pressure
    run_seq(3);
    cmp_run("seq3");

    // Zero-op loops: one tuple per cycle
    cfg_clear();
    cfg_loop(0, 0, 0, 4);
    run_seq(1);
    exp_q.delete(); for (int i = 0; i < 4; i++) exp_q.push_back(tab4[i]);
    cmp_run("nbops0");
    lat = (hs_cyc.size() >= 4) ? hs_cyc[3] - hs_cyc[0] : -1;
    chk("nbops0_span", lat, 3);

    // All ranges zero: a single tuple
    range_i = '0;
    run_seq(1);
    exp_q.delete(); exp_q.push_back(tab4[0]);
    cmp_run("range0");

    // Accumulation window over loop 0
    cfg_clear();
    cfg_loop(0, 0, 0, 2);
    cfg_loop(1, 0, 0, 3);
    accum_loop_i = 3'd1;
    run_seq(1);
    exp_q.delete(); for (int i = 0; i < 6; i++) exp_q.push_back(tab5[i]);
    cmp_run("accum");

    // Soft clear during EMIT wins over start
    prog2();
    ready_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 ready_i = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (valid_o) found = 1;
      else begin @(posedge clk_i); #1; end
    end
    chk("clr_pre_valid", 64'(found), 1);
    chk("clr_pre_offs0", 64'(offs_o[31:0]), 8);
    clear_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0; start_i = 1'b0;
    check_zero("clear");
    @(posedge clk_i); #1;
    chk("clear_next_busy", 64'(busy_o), 0);
    chk("clear_next_done", 64'(done_o), 0);

`ifdef HWPE_CTRL_USEQ_SHADOW_EN
    // Shadowed program: live range change has no effect on the running sequence
    cfg_clear();
    cfg_loop(0, 0, 0, 4);
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    range_i[0 +: CW] = 12'd2;
    lat = 0; found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (valid_o) lat++;
      if (done_o) found = 1;
      @(posedge clk_i); #1;
    end
    ready_i = 1'b0;
    chk("shadow_done", 64'(found), 1);
    chk("shadow_count", lat, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
